breath_duty_gen: RTL
====================

# breath_duty_gen

Generates the duty-cycle word that drives the board's PWM output, producing a smooth "breathing" brightness envelope. It replaces the raw counter-slice duty source. The block ramps linearly up, holds, ramps down and holds, at a programmable step rate, with optional gamma correction. It sits directly upstream of `pwm_generator` and feeds its `duty` input. Everything runs in the 12 MHz `clk` domain.

## Interface
- `WIDTH`, 8: duty/level width; must match `pwm_generator` `COUNTER_WIDTH`.
- `STEP_DIV`, 46875: clk cycles per level step. Must be ≥2. The default gives 256 steps ≈ 1 s at 12 MHz.
- `HOLD_STEPS`, 32: steps spent in each hold state. Must be ≥1.
- `GAMMA`, 1: 1 = squared output curve; 0 = linear.
- `clk` in 1: system clock, 12 MHz.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: advance enable. While low, the prescaler, state, level and duty all freeze.
- `restart` in 1: synchronous restart to the start of RAMP_UP; takes priority over `en`.
- `duty` out WIDTH: registered duty word to `pwm_generator.duty`.
- `phase` out 2: current state code.
- `cycle_done` out 1: one-clk pulse marking the end of each full breath.

## Operation
- Prescaler:
  - Counts 0..STEP_DIV-1 while `en` is high.
  - `tick` fires in the cycle where count = STEP_DIV-1; the count then wraps to 0.
- `level` register, WIDTH bits, MAX = 2^WIDTH-1.
- `hold_cnt` register, counts 0..HOLD_STEPS-1.
- States and codes: HOLD_LOW=0, RAMP_UP=1, HOLD_HIGH=2, RAMP_DOWN=3. The FSM acts only on `tick`.
- RAMP_UP:
  - level < MAX: level+1.
  - level = MAX: go to HOLD_HIGH, hold_cnt←0.
- HOLD_HIGH:
  - hold_cnt < HOLD_STEPS-1: hold_cnt+1.
  - hold_cnt = HOLD_STEPS-1: go to RAMP_DOWN, hold_cnt←0.
- RAMP_DOWN:
  - level > 0: level-1.
  - level = 0: go to HOLD_LOW.
- HOLD_LOW:
  - Same hold counting as HOLD_HIGH.
  - On the last hold tick: go to RAMP_UP and assert `cycle_done` for exactly one clk.
- Level never wraps. Increment saturates into the state change at MAX; decrement into the state change at 0.
- Output mapping:
  - GAMMA=0: duty = level.
  - GAMMA=1: duty = (level·level) >> WIDTH. Use a 2·WIDTH-bit product and take the upper WIDTH bits.
  - Examples for WIDTH=8: 255→254, 128→64, 16→1, 15→0.
- Full breath = 512 + 2·HOLD_STEPS ticks for WIDTH=8, i.e. 2·2^WIDTH + 2·HOLD_STEPS in general.
- `restart`:
  - Sets prescaler←0, level←0, hold_cnt←0, state←RAMP_UP.
  - No `cycle_done` is generated, even if a tick coincides with it.
- `en` low with a pending tick: no tick is generated. The prescaler resumes from its held count.

## Timing
- Reset values: `duty`=0, `phase`=1 (RAMP_UP), `cycle_done`=0, level=0, prescaler=0, hold_cnt=0.
- Reset is asynchronous on assert and takes effect mid-ramp or mid-hold. The first tick comes STEP_DIV enabled clks after release.
- `level` and `phase` update on the clk edge where `tick` is high.
- `duty` is registered one clk after `level`, so latency is tick → duty = 2 clk edges.
- `cycle_done` is asserted in the same cycle that `phase` becomes 1.
- `duty` changes at most once per STEP_DIV clks. `pwm_generator` samples it freely; no handshake is required.

## Structure
- Shared package `breath_pkg`:
  - State code localparams (ST_HOLD_LOW..ST_RAMP_DOWN).
  - Default STEP_DIV for 12 MHz.
- Sub-module `tick_divider` (parameter DIV; ports `clk`, `rst`, `en`, `clr`, `tick`) is a natural split. It is reusable for the LED blink dividers.
- Top-level wiring: `breath_duty_gen.duty` → `pwm_generator.duty`; `en` tied high; `restart` tied low.

## Test plan
Unless stated otherwise, use STEP_DIV=4, HOLD_STEPS=2, WIDTH=8, GAMMA=0.
- Reset:
  - Assert `rst` mid-run → duty=0, phase=1, cycle_done=0 immediately, with no clk needed.
  - After release with en=1 → duty=1 at the 5th clk edge (tick at edge 4, duty at edge 5).
- Full cycle:
  - Run to completion → duty rises 0..255, holds for 2 ticks, falls to 0, holds for 2 ticks.
  - One `cycle_done` pulse exactly 516 ticks (2064 clk) after reset; phase sequence 1,2,3,0,1.
- Enable gating: drop `en` for 10 clks mid-ramp → duty and phase unchanged throughout; the step interval stretches by exactly 10 clks.
- Restart:
  - Pulse `restart` in RAMP_DOWN at level 100 → level 0, phase 1, next tick after 4 clks.
  - `restart` coincident with the final HOLD_LOW tick → no `cycle_done`.
- Gamma: with GAMMA=1, force levels 255, 128, 16, 15 → duty 254, 64, 1, 0.
- Saturation: at MAX in RAMP_UP, the next tick → level stays 255 and phase=2. It never wraps to 0.

Source files
------------

// File: rtl/breath_pkg.sv
// Shared definitions for the breathing duty-cycle generator: state codes,
// the FSM state type built on them, and the 12 MHz default step divider.
package breath_pkg;

    localparam logic [1:0] ST_HOLD_LOW  = 2'd0;
    localparam logic [1:0] ST_RAMP_UP   = 2'd1;
    localparam logic [1:0] ST_HOLD_HIGH = 2'd2;
    localparam logic [1:0] ST_RAMP_DOWN = 2'd3;

    typedef enum logic [1:0] {
        HOLD_LOW  = ST_HOLD_LOW,
        RAMP_UP   = ST_RAMP_UP,
        HOLD_HIGH = ST_HOLD_HIGH,
        RAMP_DOWN = ST_RAMP_DOWN
    } breath_state_t;

    // 46875 clks per step gives 256 steps in about 1 s at 12 MHz.
    localparam int DEFAULT_STEP_DIV = 46875;

endpackage

// File: rtl/tick_divider.sv
// Enable-gated prescaler producing a one-clk tick every DIV enabled clks.
// Reusable for the LED blink dividers.
module tick_divider #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // A held count produces no tick, so a pending tick waits for en.
    assign tick = en && (cnt == LAST);

    // Count 0..DIV-1 while enabled; clr returns to 0 regardless of en.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of block ordering.
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/breath_duty_gen.sv
// Breathing-envelope duty source: ramp up, hold, ramp down, hold, one level
// step per prescaler tick, with an optional squared (gamma) output curve.
module breath_duty_gen
    import breath_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int STEP_DIV   = DEFAULT_STEP_DIV,
    parameter int HOLD_STEPS = 32,
    parameter int GAMMA      = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             restart,
    output logic [WIDTH-1:0] duty,
    output logic [1:0]       phase,
    output logic             cycle_done
);

    localparam int HW = (HOLD_STEPS > 2) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_STEPS - 1);
    localparam logic [WIDTH-1:0] LVL_MAX   = '1;

    breath_state_t      state_q, state_d;
    logic [WIDTH-1:0]   level_q, level_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               done_d;
    logic               tick;
    logic [WIDTH-1:0]   duty_q, duty_map;
    logic [2*WIDTH-1:0] level_sq;

    tick_divider #(
        .DIV (STEP_DIV)
    ) u_tick_divider (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (restart),
        .tick (tick)
    );

    // Next-state, level and hold counting; the FSM moves only on tick.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_d = state_q;
        level_d = level_q;
        hold_d  = hold_q;
        done_d  = 1'b0;
        if (restart) begin
            state_d = RAMP_UP;
            level_d = '0;
            hold_d  = '0;
        end else if (tick) begin
            unique case (state_q)
                RAMP_UP: begin
                    if (level_q == LVL_MAX) begin
                        state_d = HOLD_HIGH;
                        hold_d  = '0;
                    end else begin
                        level_d = level_q + 1'b1;
                    end
                end
                HOLD_HIGH: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = RAMP_DOWN;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                RAMP_DOWN: begin
                    if (level_q == '0) begin
                        state_d = HOLD_LOW;
                        hold_d  = '0;
                    end else begin
                        level_d = level_q - 1'b1;
                    end
                end
                HOLD_LOW: begin
                    if (hold_q == HOLD_LAST) begin
                        state_d = RAMP_UP;
                        hold_d  = '0;
                        done_d  = 1'b1;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                default: state_d = RAMP_UP;
            endcase
        end
    end

    // State, level and hold registers plus the end-of-breath pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RAMP_UP;
            level_q    <= '0;
            hold_q     <= '0;
            cycle_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            hold_q     <= hold_d;
            cycle_done <= done_d;
        end
    end

    // Full-width square; the upper half is level^2 / 2^WIDTH.
    assign level_sq = (2*WIDTH)'(level_q) * (2*WIDTH)'(level_q);
    assign duty_map = (GAMMA != 0) ? level_sq[2*WIDTH-1:WIDTH] : level_q;

    // Duty trails level by one clk and freezes with en.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_q <= '0;
        end else if (en) begin
            duty_q <= duty_map;
        end
    end

    assign duty  = duty_q;
    assign phase = state_q;

endmodule
